// File: rtl/mandel_pkg.sv
// ============================================================================
// mandel_pkg : shared defaults and types for the line buffer / streamer slice
// Rev 1.0
// ============================================================================
`default_nettype none

package mandel_pkg;

  localparam int DEF_SCREEN_WIDTH  = 640;
  localparam int DEF_SCREEN_HEIGHT = 480;
  localparam int DEF_DEPTH_WIDTH   = 10;

  typedef enum logic [1:0] {
    F_IDLE  = 2'd0,
    F_START = 2'd1,
    F_FILL  = 2'd2
  } fill_state_t;

  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_PRIME  = 2'd1,
    R_STREAM = 2'd2
  } read_state_t;

  typedef logic [DEF_DEPTH_WIDTH-1:0] depth_t;

endpackage

`default_nettype wire

// File: rtl/line_bank_ram.sv
// ============================================================================
// line_bank_ram : one line of depth samples, simple dual-port, 1-cycle read
// Rev 1.0
// ============================================================================
`default_nettype none

module line_bank_ram #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 10,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Read data is held when rd_en is low; the streamer relies on this to stall.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/line_buffer_streamer.sv
// ============================================================================
// line_buffer_streamer : ping-pong line capture from the calculator, replayed
// as a valid/ready pixel stream with SOF (m_user) and EOL (m_last). Rev 1.0
// ============================================================================
`default_nettype none

module line_buffer_streamer
  import mandel_pkg::*;
#(
  parameter int SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
  parameter int DEPTH_WIDTH   = DEF_DEPTH_WIDTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  output logic                            eng_start,
  input  logic                            eng_done,
  input  logic [DEPTH_WIDTH-1:0]          depth_in,
  input  logic [$clog2(SCREEN_WIDTH)-1:0] addr_in,
  input  logic                            we_in,
  output logic [DEPTH_WIDTH-1:0]          m_depth,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic                            m_last,
  output logic                            m_user,
  output logic                            err_sticky
);

  localparam int AW = $clog2(SCREEN_WIDTH);
  localparam int CW = $clog2(SCREEN_WIDTH + 1);
  localparam int NW = $clog2(SCREEN_WIDTH + 2);
  localparam int RW = (SCREEN_HEIGHT > 1) ? $clog2(SCREEN_HEIGHT) : 1;

  fill_state_t          fill_state_q, fill_state_d;
  logic                 wr_bank_q, wr_bank_d;
  logic [CW-1:0]        wr_count_q, wr_count_d;
  logic                 done_seen_q, done_seen_d;
  logic [RW-1:0]        wr_row_q, wr_row_d;
  logic [1:0][RW-1:0]   row_tag_q, row_tag_d;
  logic [1:0]           bank_full_q, bank_full_d;
  logic                 err_q, err_d;

  read_state_t          rd_state_q, rd_state_d;
  logic                 rd_bank_q, rd_bank_d;
  logic [NW-1:0]        nxt_addr_q, nxt_addr_d;
  logic [AW-1:0]        rd_x_q, rd_x_d;
  logic [DEPTH_WIDTH-1:0] m_depth_q, m_depth_d;
  logic                 m_valid_q, m_valid_d;
  logic                 m_last_q, m_last_d;
  logic                 m_user_q, m_user_d;

  logic                 wr_ok;
  logic [1:0]           set_full, clr_full;
  logic                 rd_en;
  logic [AW-1:0]        rd_addr;
  logic [DEPTH_WIDTH-1:0] bank_rdata [2];
  logic [DEPTH_WIDTH-1:0] rd_data;

  assign wr_ok = we_in && (fill_state_q == F_FILL)
              && (CW'(addr_in) < CW'(SCREEN_WIDTH))
              && (wr_count_q < CW'(SCREEN_WIDTH));

  always_comb begin
    fill_state_d = fill_state_q;
    wr_bank_d    = wr_bank_q;
    wr_count_d   = wr_count_q;
    done_seen_d  = done_seen_q;
    wr_row_d     = wr_row_q;
    row_tag_d    = row_tag_q;
    set_full     = 2'b00;
    err_d        = err_q | (we_in && !wr_ok);
    case (fill_state_q)
      F_IDLE: begin
        if (enable && !bank_full_q[wr_bank_q]) begin
          fill_state_d = F_START;
        end
      end
      F_START: begin
        wr_count_d   = '0;
        done_seen_d  = 1'b0;
        fill_state_d = F_FILL;
      end
      F_FILL: begin
        if (wr_ok) begin
          wr_count_d = wr_count_q + CW'(1);
        end
        if (eng_done) begin
          done_seen_d = 1'b1;
        end
        // Done may precede or accompany the final write; both are accepted.
        if ((wr_count_d == CW'(SCREEN_WIDTH)) && (done_seen_q || eng_done)) begin
          set_full[wr_bank_q]  = 1'b1;
          row_tag_d[wr_bank_q] = wr_row_q;
          wr_bank_d            = ~wr_bank_q;
          wr_row_d             = (wr_row_q == RW'(SCREEN_HEIGHT - 1)) ? '0 : wr_row_q + RW'(1);
          fill_state_d         = F_IDLE;
        end
      end
      default: fill_state_d = F_IDLE;
    endcase
  end

  assign rd_data = bank_rdata[rd_bank_q];

  always_comb begin
    rd_state_d = rd_state_q;
    rd_bank_d  = rd_bank_q;
    nxt_addr_d = nxt_addr_q;
    rd_x_d     = rd_x_q;
    m_depth_d  = m_depth_q;
    m_valid_d  = m_valid_q;
    m_last_d   = m_last_q;
    m_user_d   = m_user_q;
    clr_full   = 2'b00;
    rd_en      = 1'b0;
    rd_addr    = (rd_state_q == R_IDLE) ? '0 : nxt_addr_q[AW-1:0];
    case (rd_state_q)
      R_IDLE: begin
        if (bank_full_q[rd_bank_q]) begin
          rd_en      = 1'b1;
          nxt_addr_d = NW'(1);
          rd_state_d = R_PRIME;
        end
      end
      R_PRIME: begin
        m_valid_d  = 1'b1;
        m_depth_d  = rd_data;
        rd_x_d     = '0;
        m_last_d   = (SCREEN_WIDTH == 1);
        m_user_d   = (row_tag_q[rd_bank_q] == '0);
        rd_en      = (nxt_addr_q < NW'(SCREEN_WIDTH));
        nxt_addr_d = nxt_addr_q + NW'(1);
        rd_state_d = R_STREAM;
      end
      R_STREAM: begin
        // The RAM output already holds pixel x+1, so each handshake refills
        // the output register and prefetches x+2.
        if (m_valid_q && m_ready) begin
          if (m_last_q) begin
            m_valid_d           = 1'b0;
            m_last_d            = 1'b0;
            m_user_d            = 1'b0;
            clr_full[rd_bank_q] = 1'b1;
            rd_bank_d           = ~rd_bank_q;
            rd_state_d          = R_IDLE;
          end else begin
            m_depth_d  = rd_data;
            rd_x_d     = rd_x_q + AW'(1);
            m_last_d   = ((rd_x_q + AW'(1)) == AW'(SCREEN_WIDTH - 1));
            m_user_d   = 1'b0;
            rd_en      = (nxt_addr_q < NW'(SCREEN_WIDTH));
            nxt_addr_d = nxt_addr_q + NW'(1);
          end
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  assign bank_full_d = (bank_full_q & ~clr_full) | set_full;

  always_ff @(posedge clk) begin
    if (!reset) begin
      fill_state_q <= F_IDLE;
      wr_bank_q    <= 1'b0;
      wr_count_q   <= '0;
      done_seen_q  <= 1'b0;
      wr_row_q     <= '0;
      row_tag_q    <= '0;
      bank_full_q  <= 2'b00;
      err_q        <= 1'b0;
      rd_state_q   <= R_IDLE;
      rd_bank_q    <= 1'b0;
      nxt_addr_q   <= '0;
      rd_x_q       <= '0;
      m_depth_q    <= '0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      m_user_q     <= 1'b0;
    end else begin
      fill_state_q <= fill_state_d;
      wr_bank_q    <= wr_bank_d;
      wr_count_q   <= wr_count_d;
      done_seen_q  <= done_seen_d;
      wr_row_q     <= wr_row_d;
      row_tag_q    <= row_tag_d;
      bank_full_q  <= bank_full_d;
      err_q        <= err_d;
      rd_state_q   <= rd_state_d;
      rd_bank_q    <= rd_bank_d;
      nxt_addr_q   <= nxt_addr_d;
      rd_x_q       <= rd_x_d;
      m_depth_q    <= m_depth_d;
      m_valid_q    <= m_valid_d;
      m_last_q     <= m_last_d;
      m_user_q     <= m_user_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    line_bank_ram #(
      .DEPTH (SCREEN_WIDTH),
      .WIDTH (DEPTH_WIDTH)
    ) u_ram (
      .clk     (clk),
      .wr_en   (wr_ok && (wr_bank_q == 1'(b))),
      .wr_addr (addr_in),
      .wr_data (depth_in),
      .rd_en   (rd_en && (rd_bank_q == 1'(b))),
      .rd_addr (rd_addr),
      .rd_data (bank_rdata[b])
    );
  end

  assign eng_start  = (fill_state_q == F_START);
  assign m_depth    = m_depth_q;
  assign m_valid    = m_valid_q;
  assign m_last     = m_last_q;
  assign m_user     = m_user_q;
  assign err_sticky = err_q;

endmodule

`default_nettype wire
